// File: rtl/hit_detector_pkg.sv
// Shared definitions for the duck-hunt hit detector: FSM encoding, raster
// defaults shared with the VGA timing block, and the BCD digit width.
package hit_detector_pkg;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_REPORT   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam int H_TOTAL_DEFAULT = 800;
    localparam int V_TOTAL_DEFAULT = 525;

    localparam int BCD_W = 4;
    localparam int OVL_W = 10;

endpackage

// File: rtl/hit_detector_bcd_score_counter.sv
// Two-digit BCD score counter with increment enable; 99 wraps to 00.
module bcd_score_counter
    import hit_detector_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [BCD_W-1:0] tens_o,
    output logic [BCD_W-1:0] ones_o
);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc_i) begin
            if (ones_q == BCD_W'(9)) begin
                ones_d = '0;
                tens_d = (tens_q == BCD_W'(9)) ? '0 : tens_q + BCD_W'(1);
            end else begin
                ones_d = ones_q + BCD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/hit_detector.sv
// Turns coincident duck/bullet pixels into per-frame hit events, reports them
// over req/ack, applies a frame-based cooldown and keeps a BCD score.
module hit_detector
    import hit_detector_pkg::*;
#(
    parameter int H_TOTAL         = H_TOTAL_DEFAULT,
    parameter int V_TOTAL         = V_TOTAL_DEFAULT,
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    input  logic             duck_draw,
    input  logic             shot_drawer,
    output logic             hit_req,
    input  logic             hit_ack,
    output logic [BCD_W-1:0] score_tens,
    output logic [BCD_W-1:0] score_ones,
    output logic             busy
);

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 2);

    logic [1:0]       state_q, state_d;
    logic [OVL_W-1:0] ovl_q, ovl_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             hit_req_q, busy_q;
    logic             score_inc;

    logic             frame_end;
    logic             overlap;
    logic [OVL_W:0]   ovl_sum;
    logic             verdict;

    assign frame_end = (hcount == 10'(H_TOTAL - 1)) && (vcount == 10'(V_TOTAL - 1));
    assign overlap   = duck_draw & shot_drawer;
    // The last pixel of the frame is still counted toward that frame's verdict.
    assign ovl_sum   = {1'b0, ovl_q} + {{OVL_W{1'b0}}, overlap};
    assign verdict   = ovl_sum >= (OVL_W + 1)'(MIN_OVERLAP);

    always_comb begin
        ovl_d = ovl_q;
        if (frame_end) begin
            ovl_d = '0;
        end else if (overlap && (ovl_q != {OVL_W{1'b1}})) begin
            ovl_d = ovl_q + OVL_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        cd_d      = cd_q;
        score_inc = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (frame_end && verdict) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (hit_ack) begin
                    score_inc = 1'b1;
                    cd_d      = CD_W'(COOLDOWN_FRAMES);
                    state_d   = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                // A zero load (COOLDOWN_FRAMES=0) leaves on the very next cycle.
                if (cd_q == '0) begin
                    state_d = ST_SCAN;
                end else if (frame_end) begin
                    cd_d = cd_q - CD_W'(1);
                    if (cd_q == CD_W'(1)) begin
                        state_d = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SCAN;
            ovl_q     <= '0;
            cd_q      <= '0;
            hit_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ovl_q     <= ovl_d;
            cd_q      <= cd_d;
            hit_req_q <= (state_d == ST_REPORT);
            busy_q    <= (state_d != ST_SCAN);
        end
    end

    bcd_score_counter u_score (
        .clk_i  (vga_clk),
        .rst_ni (reset),
        .inc_i  (score_inc),
        .tens_o (score_tens),
        .ones_o (score_ones)
    );

    assign hit_req = hit_req_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_hit_detector.sv
// Directed plus randomized checks of hit_detector against an integer-level
// model of the hit/report/cooldown/score rules.
module tb_hit_detector;

    localparam int H   = 800;
    localparam int V   = 525;
    localparam int MIN = 4;
    localparam int CD  = 30;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [9:0] hcount  = '0;
    logic [9:0] vcount  = '0;
    logic       duck_draw = 1'b0;
    logic       shot_drawer = 1'b0;
    logic       hit_ack = 1'b0;
    logic       hit_req;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_rep, m_cool;
    int m_cd, m_cnt, m_score;

    hit_detector dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .duck_draw   (duck_draw),
        .shot_drawer (shot_drawer),
        .hit_req     (hit_req),
        .hit_ack     (hit_ack),
        .score_tens  (score_tens),
        .score_ones  (score_ones),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [7:0] bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rep = 0; m_cool = 0; m_cd = 0; m_cnt = 0; m_score = 0;
    endtask

    task automatic model(input int h, input int v, input bit d, input bit s, input bit a);
        bit fe, ov;
        fe = (h == H - 1) && (v == V - 1);
        ov = d && s;
        if (m_rep) begin
            if (a) begin
                m_rep = 0; m_cool = 1; m_cd = CD;
                m_score = (m_score + 1) % 100;
            end
        end else if (m_cool) begin
            if (m_cd == 0) m_cool = 0;
            else if (fe) begin
                m_cd--;
                if (m_cd == 0) m_cool = 0;
            end
        end else if (fe && (m_cnt + int'(ov) >= MIN)) begin
            m_rep = 1;
        end
        if (fe) m_cnt = 0;
        else if (ov && m_cnt < 1023) m_cnt++;
    endtask

    task automatic step(input int h, input int v, input bit d, input bit s, input bit a);
        hcount = 10'(h); vcount = 10'(v);
        duck_draw = d; shot_drawer = s; hit_ack = a;
        @(posedge vga_clk);
        model(h, v, d, s, a);
        #1;
        chk("req", {7'b0, hit_req}, {7'b0, m_rep});
        chk("busy", {7'b0, busy}, {7'b0, m_rep | m_cool});
        chk("score", {score_tens, score_ones}, bcd(m_score));
    endtask

    task automatic hit_frame(input int n_ov, input bit last_ov, input bit a_last);
        for (int i = 0; i < n_ov; i++) step(10 + i, 100, 1, 1, 0);
        step(60, 100, 1, 0, 0);
        step(61, 100, 0, 1, 0);
        step(H - 1, V - 1, last_ov, last_ov, a_last);
    endtask

    task automatic cool(input int n);
        repeat (n) step(H - 1, V - 1, 0, 0, 0);
    endtask

    task automatic one_hit();
        hit_frame(MIN, 0, 0);
        step(0, 0, 0, 0, 1);
        cool(CD);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_req", {7'b0, hit_req}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_score", {score_tens, score_ones}, 8'h00);
        reset = 1'b1;

        // 4 overlaps on line 100, ack 10 cycles later
        hit_frame(4, 0, 0);
        chk("t1_req", {7'b0, hit_req}, 8'h01);
        repeat (9) step(0, 0, 0, 0, 0);
        chk("t1_hold", {7'b0, hit_req}, 8'h01);
        step(0, 0, 0, 0, 1);
        chk("t1_req_fall", {7'b0, hit_req}, 8'h00);
        chk("t1_score", {score_tens, score_ones}, 8'h01);
        chk("t1_busy", {7'b0, busy}, 8'h01);
        cool(29);
        chk("t1_cool29", {7'b0, busy}, 8'h01);
        cool(1);
        chk("t1_cool30", {7'b0, busy}, 8'h00);

        // final-pixel overlap completes the count
        hit_frame(3, 1, 0);
        chk("t2_last_px", {7'b0, hit_req}, 8'h01);
        step(0, 0, 0, 0, 1);
        cool(CD);
        hit_frame(3, 0, 0);
        chk("t2_three", {7'b0, hit_req}, 8'h00);

        // ack coincident with the qualifying frame_end is not taken
        hit_frame(4, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("early_ack_req", {7'b0, hit_req}, 8'h01);
        chk("early_ack_score", {score_tens, score_ones}, 8'h02);
        step(0, 0, 0, 0, 1);
        cool(CD);

        // 5 consecutive hit frames, immediate ack
        hit_frame(4, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (4) hit_frame(4, 0, 0);
        chk("t3_score", {score_tens, score_ones}, 8'h04);
        chk("t3_req", {7'b0, hit_req}, 8'h00);
        repeat (25) hit_frame(4, 0, 0);
        chk("t3_busy29", {7'b0, busy}, 8'h01);
        hit_frame(4, 0, 0);
        chk("t3_busy30", {7'b0, busy}, 8'h00);
        chk("t3_req30", {7'b0, hit_req}, 8'h00);
        hit_frame(4, 0, 0);
        chk("t3_next_hit", {7'b0, hit_req}, 8'h01);
        step(0, 0, 0, 0, 1);
        cool(CD);

        // ack held through REPORT and 20 more cycles
        hit_frame(4, 0, 0);
        repeat (21) step(0, 0, 0, 0, 1);
        chk("held_score", {score_tens, score_ones}, 8'h06);
        cool(CD);
        repeat (3) step(5, 5, 0, 0, 1);
        chk("scan_ack_score", {score_tens, score_ones}, 8'h06);
        chk("scan_ack_req", {7'b0, hit_req}, 8'h00);

        // counter saturates rather than wrapping at 1024 overlaps
        repeat (1024) step(20, 200, 1, 1, 0);
        step(H - 1, V - 1, 0, 0, 0);
        chk("sat_req", {7'b0, hit_req}, 8'h01);
        step(0, 0, 0, 0, 1);
        cool(CD);

        // score wrap
        while (m_score != 99) one_hit();
        chk("score99", {score_tens, score_ones}, 8'h99);
        one_hit();
        chk("score_wrap", {score_tens, score_ones}, 8'h00);

        // async reset in REPORT
        one_hit();
        hit_frame(4, 0, 0);
        chk("pre_rst_req", {7'b0, hit_req}, 8'h01);
        #2 reset = 1'b0;
        #1;
        chk("async_req", {7'b0, hit_req}, 8'h00);
        chk("async_busy", {7'b0, busy}, 8'h00);
        chk("async_score", {score_tens, score_ones}, 8'h00);
        model_reset();
        #2 reset = 1'b1;
        hit_frame(4, 0, 0);
        chk("post_rst_req", {7'b0, hit_req}, 8'h01);
        step(0, 0, 0, 0, 1);
        chk("post_rst_score", {score_tens, score_ones}, 8'h01);

        // randomized frames
        for (int f = 0; f < 200; f++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int p = 0; p < n; p++)
                step($urandom_range(0, H - 2), $urandom_range(0, V - 2),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 3) == 0);
            step(H - 1, V - 1, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
